// File: rtl/rdma_rx_udp_decap.sv
// Ethernet II / IPv4 / UDP receive decapsulator: filters on dst MAC, dst IP and UDP port,
// realigns the UDP payload to word boundaries. Optional IPv4 header checksum check under RDMA_RX_IPCSUM_EN.
module rdma_rx_udp_decap #(
  parameter logic [47:0] LOCAL_MAC = 48'h000A35000001,
  parameter logic [31:0] LOCAL_IP  = 32'hC0A80102,
  parameter logic [15:0] UDP_PORT  = 16'd4791
) (
  input  logic        axis_clk,
  input  logic        axis_areset,
  input  logic [31:0] s_axis_eth_tdata,
  input  logic [3:0]  s_axis_eth_tkeep,
  input  logic        s_axis_eth_tvalid,
  output logic        s_axis_eth_tready,
  input  logic        s_axis_eth_tlast,
  output logic [31:0] m_axis_pl_tdata,
  output logic [3:0]  m_axis_pl_tkeep,
  output logic        m_axis_pl_tvalid,
  input  logic        m_axis_pl_tready,
  output logic        m_axis_pl_tlast,
  output logic        m_axis_pl_tuser,
  output logic [47:0] hdr_src_mac,
  output logic [31:0] hdr_src_ip,
  output logic [15:0] hdr_src_port,
  output logic [15:0] hdr_udp_len,
  output logic [15:0] frames_ok,
  output logic [15:0] frames_dropped
);

  localparam int unsigned BEAT_CNT_W = 4;
  localparam logic [BEAT_CNT_W-1:0] BEAT_DECIDE  = BEAT_CNT_W'(9);
  localparam logic [BEAT_CNT_W-1:0] BEAT_PL_FIRST = BEAT_CNT_W'(10);
  localparam logic [47:0] BCAST_MAC   = 48'hFFFF_FFFF_FFFF;
  localparam logic [15:0] ETYPE_IPV4  = 16'h0800;
  localparam logic [7:0]  IPV4_VIHL   = 8'h45;
  localparam logic [7:0]  IPPROTO_UDP = 8'h11;

  typedef enum logic [1:0] {
    ST_HDR,
    ST_PAYLOAD,
    ST_FLUSH,
    ST_DROP
  } state_t;

  state_t                state;
  logic [BEAT_CNT_W-1:0] beat_cnt;
  logic [47:0]           dst_mac;
  logic [47:0]           src_mac;
  logic [15:0]           ethertype;
  logic [7:0]            ver_ihl;
  logic [7:0]            ip_proto;
  logic [31:0]           src_ip;
  logic [31:0]           dst_ip;
  logic [15:0]           src_port;
  logic [15:0]           carry;
  logic [1:0]            last_keep_hi;
  logic                  first_beat;

  logic        in_fire;
  logic        out_free;
  logic        hdr_match;
  logic [15:0] cur_lo16;
  logic [15:0] cur_hi16;

  function automatic logic [15:0] sat_inc(input logic [15:0] c);
    return (c == 16'hFFFF) ? c : c + 16'd1;
  endfunction

  // Lane 0 is the first byte on the wire; header fields are big-endian.
  assign cur_lo16 = {s_axis_eth_tdata[7:0],   s_axis_eth_tdata[15:8]};
  assign cur_hi16 = {s_axis_eth_tdata[23:16], s_axis_eth_tdata[31:24]};

  assign out_free = !m_axis_pl_tvalid || m_axis_pl_tready;
  assign s_axis_eth_tready = !axis_areset &&
                             ((state == ST_HDR) || (state == ST_DROP) ||
                              ((state == ST_PAYLOAD) && out_free));
  assign in_fire = s_axis_eth_tvalid && s_axis_eth_tready;

`ifdef RDMA_RX_IPCSUM_EN
  logic [15:0] csum_acc;

  function automatic logic [15:0] ones_add(input logic [15:0] a, input logic [15:0] b);
    logic [16:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[15:0] + 16'(s[16]);
  endfunction

  always_ff @(posedge axis_clk or posedge axis_areset) begin
    if (axis_areset) begin
      csum_acc <= '0;
    end else if (in_fire && (state == ST_HDR)) begin
      case (beat_cnt)
        BEAT_CNT_W'(3): csum_acc <= ones_add(16'h0, cur_hi16);
        BEAT_CNT_W'(4), BEAT_CNT_W'(5), BEAT_CNT_W'(6), BEAT_CNT_W'(7):
          csum_acc <= ones_add(ones_add(csum_acc, cur_lo16), cur_hi16);
        BEAT_CNT_W'(8): csum_acc <= ones_add(csum_acc, cur_lo16);
        default: csum_acc <= csum_acc;
      endcase
    end
  end

  assign hdr_match = ((dst_mac == LOCAL_MAC) || (dst_mac == BCAST_MAC)) &&
                     (ethertype == ETYPE_IPV4) && (ver_ihl == IPV4_VIHL) &&
                     (ip_proto == IPPROTO_UDP) && (dst_ip == LOCAL_IP) &&
                     (cur_lo16 == UDP_PORT) && (csum_acc == 16'hFFFF);
`else
  assign hdr_match = ((dst_mac == LOCAL_MAC) || (dst_mac == BCAST_MAC)) &&
                     (ethertype == ETYPE_IPV4) && (ver_ihl == IPV4_VIHL) &&
                     (ip_proto == IPPROTO_UDP) && (dst_ip == LOCAL_IP) &&
                     (cur_lo16 == UDP_PORT);
`endif

  always_ff @(posedge axis_clk or posedge axis_areset) begin
    if (axis_areset) begin
      state            <= ST_HDR;
      beat_cnt         <= '0;
      dst_mac          <= '0;
      src_mac          <= '0;
      ethertype        <= '0;
      ver_ihl          <= '0;
      ip_proto         <= '0;
      src_ip           <= '0;
      dst_ip           <= '0;
      src_port         <= '0;
      carry            <= '0;
      last_keep_hi     <= '0;
      first_beat       <= 1'b0;
      m_axis_pl_tdata  <= '0;
      m_axis_pl_tkeep  <= '0;
      m_axis_pl_tvalid <= 1'b0;
      m_axis_pl_tlast  <= 1'b0;
      m_axis_pl_tuser  <= 1'b0;
      hdr_src_mac      <= '0;
      hdr_src_ip       <= '0;
      hdr_src_port     <= '0;
      hdr_udp_len      <= '0;
      frames_ok        <= '0;
      frames_dropped   <= '0;
    end else begin
      // A consumed output beat frees the slot; any load below takes priority.
      if (m_axis_pl_tvalid && m_axis_pl_tready) m_axis_pl_tvalid <= 1'b0;

      case (state)
        ST_HDR: begin
          if (in_fire) begin
            if (beat_cnt == BEAT_PL_FIRST) begin
              // Beat 10 holds the first two payload bytes in lanes 2-3.
              carry        <= s_axis_eth_tdata[31:16];
              beat_cnt     <= '0;
              first_beat   <= 1'b1;
              last_keep_hi <= s_axis_eth_tkeep[3:2];
              if (!s_axis_eth_tlast)          state <= ST_PAYLOAD;
              else if (s_axis_eth_tkeep[2])   state <= ST_FLUSH;
              else                            frames_dropped <= sat_inc(frames_dropped);
            end else if (beat_cnt == BEAT_DECIDE) begin
              beat_cnt <= '0;
              if (s_axis_eth_tlast) begin
                frames_dropped <= sat_inc(frames_dropped);
              end else if (!hdr_match) begin
                state <= ST_DROP;
              end else begin
                beat_cnt     <= BEAT_PL_FIRST;
                hdr_src_mac  <= src_mac;
                hdr_src_ip   <= src_ip;
                hdr_src_port <= src_port;
                hdr_udp_len  <= cur_hi16;
              end
            end else begin
              case (beat_cnt)
                BEAT_CNT_W'(0): dst_mac[47:16] <= {cur_lo16, cur_hi16};
                BEAT_CNT_W'(1): begin
                  dst_mac[15:0]  <= cur_lo16;
                  src_mac[47:32] <= cur_hi16;
                end
                BEAT_CNT_W'(2): src_mac[31:0] <= {cur_lo16, cur_hi16};
                BEAT_CNT_W'(3): begin
                  ethertype <= cur_lo16;
                  ver_ihl   <= s_axis_eth_tdata[23:16];
                end
                BEAT_CNT_W'(5): ip_proto <= s_axis_eth_tdata[31:24];
                BEAT_CNT_W'(6): src_ip[31:16] <= cur_hi16;
                BEAT_CNT_W'(7): begin
                  src_ip[15:0]  <= cur_lo16;
                  dst_ip[31:16] <= cur_hi16;
                end
                BEAT_CNT_W'(8): begin
                  dst_ip[15:0] <= cur_lo16;
                  src_port     <= cur_hi16;
                end
                default: ;
              endcase
              if (s_axis_eth_tlast) begin
                beat_cnt       <= '0;
                frames_dropped <= sat_inc(frames_dropped);
              end else begin
                beat_cnt <= beat_cnt + BEAT_CNT_W'(1);
              end
            end
          end
        end

        ST_PAYLOAD: begin
          if (in_fire) begin
            m_axis_pl_tdata  <= {s_axis_eth_tdata[15:0], carry};
            m_axis_pl_tvalid <= 1'b1;
            m_axis_pl_tuser  <= first_beat;
            first_beat       <= 1'b0;
            carry            <= s_axis_eth_tdata[31:16];
            last_keep_hi     <= s_axis_eth_tkeep[3:2];
            if (s_axis_eth_tlast && !s_axis_eth_tkeep[2]) begin
              m_axis_pl_tkeep <= {s_axis_eth_tkeep[1:0], 2'b11};
              m_axis_pl_tlast <= 1'b1;
              frames_ok       <= sat_inc(frames_ok);
              state           <= ST_HDR;
            end else begin
              m_axis_pl_tkeep <= 4'hF;
              m_axis_pl_tlast <= 1'b0;
              if (s_axis_eth_tlast) state <= ST_FLUSH;
            end
          end
        end

        ST_FLUSH: begin
          if (out_free) begin
            m_axis_pl_tdata  <= {16'h0, carry};
            m_axis_pl_tkeep  <= {2'b00, last_keep_hi};
            m_axis_pl_tvalid <= 1'b1;
            m_axis_pl_tlast  <= 1'b1;
            m_axis_pl_tuser  <= first_beat;
            first_beat       <= 1'b0;
            frames_ok        <= sat_inc(frames_ok);
            state            <= ST_HDR;
          end
        end

        ST_DROP: begin
          if (in_fire && s_axis_eth_tlast) begin
            frames_dropped <= sat_inc(frames_dropped);
            state          <= ST_HDR;
          end
        end

        default: state <= ST_HDR;
      endcase
    end
  end

endmodule

// File: tb/tb_rdma_rx_udp_decap.sv
// Scoreboard bench for rdma_rx_udp_decap: builds frames byte-wise, predicts the realigned payload
// stream and counters, and compares against the DUT output under optional backpressure.
module tb_rdma_rx_udp_decap;

  localparam logic [47:0] LOCAL_MAC = 48'h000A35000001;
  localparam logic [31:0] LOCAL_IP  = 32'hC0A80102;
  localparam logic [15:0] UDP_PORT  = 16'd4791;
  localparam logic [47:0] SRC_MAC   = 48'h021122334455;
  localparam logic [31:0] SRC_IP    = 32'hC0A80163;
  localparam logic [15:0] SRC_PORT  = 16'hC123;

  logic        axis_clk = 1'b0;
  logic        axis_areset = 1'b1;
  logic [31:0] s_tdata = '0;
  logic [3:0]  s_tkeep = '0;
  logic        s_tvalid = 1'b0;
  logic        s_tready;
  logic        s_tlast = 1'b0;
  logic [31:0] m_tdata;
  logic [3:0]  m_tkeep;
  logic        m_tvalid;
  logic        m_tready = 1'b0;
  logic        m_tlast;
  logic        m_tuser;
  logic [47:0] hdr_src_mac;
  logic [31:0] hdr_src_ip;
  logic [15:0] hdr_src_port;
  logic [15:0] hdr_udp_len;
  logic [15:0] frames_ok;
  logic [15:0] frames_dropped;

  logic bp_mode = 1'b0;
  logic rdy_level = 1'b1;

  typedef logic [7:0] bytes_t[$];
  typedef struct packed {
    logic [31:0] data;
    logic [3:0]  keep;
    logic        last;
    logic        user;
  } beat_t;

  beat_t sb_q[$];
  int n_checks = 0;
  int n_fail = 0;
  int exp_ok = 0;
  int exp_drop = 0;

  rdma_rx_udp_decap #(.LOCAL_MAC(LOCAL_MAC), .LOCAL_IP(LOCAL_IP), .UDP_PORT(UDP_PORT)) dut (
    .axis_clk(axis_clk), .axis_areset(axis_areset),
    .s_axis_eth_tdata(s_tdata), .s_axis_eth_tkeep(s_tkeep), .s_axis_eth_tvalid(s_tvalid),
    .s_axis_eth_tready(s_tready), .s_axis_eth_tlast(s_tlast),
    .m_axis_pl_tdata(m_tdata), .m_axis_pl_tkeep(m_tkeep), .m_axis_pl_tvalid(m_tvalid),
    .m_axis_pl_tready(m_tready), .m_axis_pl_tlast(m_tlast), .m_axis_pl_tuser(m_tuser),
    .hdr_src_mac(hdr_src_mac), .hdr_src_ip(hdr_src_ip), .hdr_src_port(hdr_src_port),
    .hdr_udp_len(hdr_udp_len), .frames_ok(frames_ok), .frames_dropped(frames_dropped)
  );

  always #5 axis_clk = ~axis_clk;

  always @(posedge axis_clk) begin
    #1;
    m_tready = bp_mode ? ~m_tready : rdy_level;
  end

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  // Output monitor: scoreboard pop on handshake, and hold check while stalled.
  beat_t prev_out;
  logic  prev_stall = 1'b0;
  always @(negedge axis_clk) begin
    beat_t cur, e;
    cur = {m_tdata, m_tkeep, m_tlast, m_tuser};
    if (axis_areset) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        check_eq("hold_valid", m_tvalid, 1'b1);
        check_eq("hold_beat", cur, prev_out);
      end
      if (m_tvalid && m_tready) begin
        if (sb_q.size() == 0) begin
          check_eq("unexpected_beat", cur, 0);
        end else begin
          e = sb_q.pop_front();
          check_eq("pl_data", m_tdata, e.data);
          check_eq("pl_keep", m_tkeep, e.keep);
          check_eq("pl_last", m_tlast, e.last);
          check_eq("pl_user", m_tuser, e.user);
        end
      end
      prev_stall = m_tvalid && !m_tready;
      prev_out = cur;
    end
  end

  function automatic bytes_t build_frame(input logic [47:0] dmac, input logic [15:0] etype,
                                         input logic [31:0] dip, input logic [15:0] dport,
                                         input int plen, input logic [7:0] seed,
                                         input logic bad_csum);
    bytes_t f;
    logic [31:0] sum;
    logic [15:0] ck, tot, ulen;
    tot = 16'(28 + plen);
    ulen = 16'(8 + plen);
    for (int i = 0; i < 6; i++) f.push_back(dmac[8*(5-i) +: 8]);
    for (int i = 0; i < 6; i++) f.push_back(SRC_MAC[8*(5-i) +: 8]);
    f.push_back(etype[15:8]); f.push_back(etype[7:0]);
    f.push_back(8'h45); f.push_back(8'h00); f.push_back(tot[15:8]); f.push_back(tot[7:0]);
    f.push_back(8'h12); f.push_back(8'h34); f.push_back(8'h40); f.push_back(8'h00);
    f.push_back(8'h40); f.push_back(8'h11); f.push_back(8'h00); f.push_back(8'h00);
    for (int i = 0; i < 4; i++) f.push_back(SRC_IP[8*(3-i) +: 8]);
    for (int i = 0; i < 4; i++) f.push_back(dip[8*(3-i) +: 8]);
    f.push_back(SRC_PORT[15:8]); f.push_back(SRC_PORT[7:0]);
    f.push_back(dport[15:8]); f.push_back(dport[7:0]);
    f.push_back(ulen[15:8]); f.push_back(ulen[7:0]);
    f.push_back(8'h00); f.push_back(8'h00);
    for (int i = 0; i < plen; i++) f.push_back(8'(int'(seed) + i + 1));
    sum = 0;
    for (int i = 14; i < 34; i += 2) sum += {16'h0, f[i], f[i+1]};
    while (sum[31:16] != 0) sum = {16'h0, sum[15:0]} + {16'h0, sum[31:16]};
    ck = ~sum[15:0];
    f[24] = ck[15:8];
    f[25] = ck[7:0];
    if (bad_csum) f[24] = f[24] ^ 8'h5A;
    return f;
  endfunction

  task automatic push_expected(input bytes_t f);
    beat_t b;
    for (int i = 42; i < f.size(); i += 4) begin
      b = '0;
      for (int k = 0; k < 4; k++) begin
        if (i + k < f.size()) begin
          b.data[8*k +: 8] = f[i+k];
          b.keep[k] = 1'b1;
        end
      end
      b.last = (i + 4 >= f.size());
      b.user = (i == 42);
      sb_q.push_back(b);
    end
  endtask

  task automatic send_frame(input bytes_t f, input int max_beats, output int stalls);
    int nb_full, nb, t;
    nb_full = (f.size() + 3) / 4;
    nb = (max_beats >= 0 && max_beats < nb_full) ? max_beats : nb_full;
    stalls = 0;
    for (int b = 0; b < nb; b++) begin
      s_tdata = '0;
      s_tkeep = '0;
      for (int k = 0; k < 4; k++) begin
        if (4*b + k < f.size()) begin
          s_tdata[8*k +: 8] = f[4*b+k];
          s_tkeep[k] = 1'b1;
        end
      end
      s_tlast = (b == nb_full - 1);
      s_tvalid = 1'b1;
      @(negedge axis_clk);
      t = 0;
      while (!s_tready && t < 200) begin
        stalls++;
        t++;
        @(negedge axis_clk);
      end
      if (t >= 200) check_eq("in_timeout", 1, 0);
      @(posedge axis_clk);
      #1;
    end
    s_tvalid = 1'b0;
    s_tlast = 1'b0;
    s_tkeep = '0;
    s_tdata = '0;
  endtask

  task automatic run_frame(input bytes_t f, input logic accept, output int stalls);
    if (accept) begin
      push_expected(f);
      exp_ok++;
    end else begin
      exp_drop++;
    end
    send_frame(f, -1, stalls);
  endtask

  task automatic drain_and_check(input string tag);
    int t;
    t = 0;
    while (sb_q.size() != 0 && t < 500) begin
      @(negedge axis_clk);
      t++;
    end
    check_eq({tag, "_drain"}, sb_q.size(), 0);
    repeat (3) @(negedge axis_clk);
    check_eq({tag, "_frames_ok"}, frames_ok, exp_ok);
    check_eq({tag, "_frames_dropped"}, frames_dropped, exp_drop);
    @(posedge axis_clk);
    #1;
  endtask

  initial begin
    bytes_t f;
    int stalls;
    int plens[6];
    plens = '{1, 2, 3, 4, 7, 30};

    repeat (3) @(posedge axis_clk);
    #1;
    check_eq("rst_m_tvalid", m_tvalid, 0);
    check_eq("rst_s_tready", s_tready, 0);
    check_eq("rst_frames_ok", frames_ok, 0);
    check_eq("rst_frames_dropped", frames_dropped, 0);
    check_eq("rst_hdr_src_ip", hdr_src_ip, 0);
    axis_areset = 1'b0;
    @(posedge axis_clk);
    #1;
    check_eq("idle_s_tready", s_tready, 1);

    // Reference frame: 18-byte payload 01..12, ends in a flush beat.
    f = build_frame(LOCAL_MAC, 16'h0800, LOCAL_IP, UDP_PORT, 18, 8'h00, 1'b0);
    run_frame(f, 1'b1, stalls);
    drain_and_check("good60");
    check_eq("hdr_udp_len", hdr_udp_len, 16'd26);
    check_eq("hdr_src_mac", hdr_src_mac, SRC_MAC);
    check_eq("hdr_src_ip", hdr_src_ip, SRC_IP);
    check_eq("hdr_src_port", hdr_src_port, SRC_PORT);

    f = build_frame(LOCAL_MAC, 16'h0800, LOCAL_IP, 16'd4792, 18, 8'h00, 1'b0);
    run_frame(f, 1'b0, stalls);
    check_eq("drop_tready_stalls", stalls, 0);
    drain_and_check("badport");
    check_eq("hdr_udp_len_held", hdr_udp_len, 16'd26);

    // Runt ending on beat 6, then a frame whose last beat carries one byte.
    f = build_frame(LOCAL_MAC, 16'h0800, LOCAL_IP, UDP_PORT, 18, 8'h00, 1'b0);
    while (f.size() > 26) void'(f.pop_back());
    run_frame(f, 1'b0, stalls);
    f = build_frame(LOCAL_MAC, 16'h0800, LOCAL_IP, UDP_PORT, 19, 8'h20, 1'b0);
    run_frame(f, 1'b1, stalls);
    drain_and_check("runt_then_good");
    check_eq("hdr_udp_len_27", hdr_udp_len, 16'd27);

    // Header-only frame (no payload byte in beat 10) is a runt.
    f = build_frame(LOCAL_MAC, 16'h0800, LOCAL_IP, UDP_PORT, 0, 8'h00, 1'b0);
    run_frame(f, 1'b0, stalls);
    drain_and_check("hdr_only");

    bp_mode = 1'b1;
    f = build_frame(LOCAL_MAC, 16'h0800, LOCAL_IP, UDP_PORT, 18, 8'h00, 1'b0);
    run_frame(f, 1'b1, stalls);
    f = build_frame(48'hFFFF_FFFF_FFFF, 16'h0800, LOCAL_IP, UDP_PORT, 25, 8'h40, 1'b0);
    run_frame(f, 1'b1, stalls);
    f = build_frame(LOCAL_MAC, 16'h0800, 32'hC0A80103, UDP_PORT, 10, 8'h00, 1'b0);
    run_frame(f, 1'b0, stalls);
    f = build_frame(LOCAL_MAC, 16'h86DD, LOCAL_IP, UDP_PORT, 10, 8'h00, 1'b0);
    run_frame(f, 1'b0, stalls);
    f = build_frame(48'h000A35000002, 16'h0800, LOCAL_IP, UDP_PORT, 10, 8'h00, 1'b0);
    run_frame(f, 1'b0, stalls);
    foreach (plens[i]) begin
      f = build_frame(LOCAL_MAC, 16'h0800, LOCAL_IP, UDP_PORT, plens[i], 8'(8'h60 + i*16), 1'b0);
      run_frame(f, 1'b1, stalls);
    end
    drain_and_check("backpressure");
    bp_mode = 1'b0;
    rdy_level = 1'b1;
    repeat (2) @(posedge axis_clk);
    #1;

    f = build_frame(LOCAL_MAC, 16'h0800, LOCAL_IP, UDP_PORT, 12, 8'h80, 1'b1);
`ifdef RDMA_RX_IPCSUM_EN
    run_frame(f, 1'b0, stalls);
`else
    run_frame(f, 1'b1, stalls);
`endif
    f = build_frame(LOCAL_MAC, 16'h0800, LOCAL_IP, UDP_PORT, 12, 8'h90, 1'b0);
    run_frame(f, 1'b1, stalls);
    drain_and_check("ipcsum");

    // Reset while a payload beat is stalled at the output.
    rdy_level = 1'b0;
    @(posedge axis_clk);
    #1;
    f = build_frame(LOCAL_MAC, 16'h0800, LOCAL_IP, UDP_PORT, 18, 8'hA0, 1'b0);
    send_frame(f, 12, stalls);
    @(negedge axis_clk);
    check_eq("pre_rst_m_tvalid", m_tvalid, 1);
    axis_areset = 1'b1;
    #1;
    check_eq("mid_rst_m_tvalid", m_tvalid, 0);
    check_eq("mid_rst_m_tdata", m_tdata, 0);
    check_eq("mid_rst_s_tready", s_tready, 0);
    check_eq("mid_rst_frames_ok", frames_ok, 0);
    check_eq("mid_rst_hdr_src_mac", hdr_src_mac, 0);
    sb_q.delete();
    exp_ok = 0;
    exp_drop = 0;
    rdy_level = 1'b1;
    repeat (2) @(posedge axis_clk);
    #1;
    axis_areset = 1'b0;
    @(posedge axis_clk);
    #1;
    f = build_frame(LOCAL_MAC, 16'h0800, LOCAL_IP, UDP_PORT, 21, 8'hB0, 1'b0);
    run_frame(f, 1'b1, stalls);
    drain_and_check("after_reset");

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
